uart_rx_buffer: RTL and testbench
=================================

Name: uart_rx_buffer

Overview:
- Parametrised receive buffer for the next-generation UART: successor to the fixed 16-entry, 8-bit 16550 Rx FIFO.
- Sits between the receiver shift logic and the register interface.
- Stores data plus per-character error tags (bi/fe/pe), and supplies LSR/IIR status: data ready, trigger reached, FIFO error, overrun, character timeout.
- Supports a 16550 non-FIFO mode (depth 1).

Parameters:
DEPTH, 16, FIFO entries; power of 2, >=4
DATA_SIZE, 8, character width in bits
TIMEOUT_CHARS, 4, idle character times before timeout_o asserts; >=1

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  asynchronous, active-high reset
ena_i  in  1  FIFO mode enable (FCR.ena); 0 = single-entry holding-register mode
clr_i  in  1  synchronous flush (FCR rx_rst), single-cycle pulse
trigger_i  in  2  Rx trigger select (FCR rx_trigger encoding)
char_tick_i  in  1  one-cycle pulse per character time, from baud generator
wr_i  in  1  push strobe from receiver
wr_d_i  in  DATA_SIZE  received character
wr_bi_i, wr_fe_i, wr_pe_i  in  1 each  break / framing / parity tags for wr_d_i
rd_i  in  1  pop strobe (RBR read)
rd_d_o  out  DATA_SIZE  head character
rd_bi_o, rd_fe_o, rd_pe_o  out  1 each  head error tags
count_o  out  $clog2(DEPTH+1)  entries held
dr_o  out  1  data ready (count_o != 0)
full_o  out  1  count_o == effective depth
trigger_o  out  1  count_o >= trigger level
fifo_error_o  out  1  at least one held entry has bi|fe|pe set (LSR bit 7)
overrun_o  out  1  one-cycle pulse when a character is lost
timeout_o  out  1  character timeout indication

Behaviour:
- Reset (async, rst_i=1):
  - pointers, count, error counter, timeout counter, timeout_o, overrun_o all 0.
  - Storage array is not reset.
  - dr_o=0, full_o=0, trigger_o=0, fifo_error_o=0.
- Effective depth is DEPTH when ena_i=1, else 1.
- Head outputs: first-word-fall-through from the registered storage array, valid the same cycle dr_o=1. rd_d_o and the rd_*_o tags are forced to 0 while dr_o=0.
- Write: wr_i & !full_o stores {bi,fe,pe,d} at the write pointer. Visible at the head one cycle later.
- Read: rd_i & dr_o advances the read pointer. rd_i while empty is ignored (no underflow, count stays 0).
- Simultaneous rd_i & wr_i:
  - Both take effect; count unchanged.
  - When full, the write is accepted and there is no overrun.
  - When empty, only the write occurs.
- Overrun: wr_i while full and no rd_i drops the new character. overrun_o=1 for exactly that next cycle. Stored entries are untouched.
- Pointers: $clog2(DEPTH) bits, natural wrap. count_o is kept as an explicit counter.
- Trigger level: trigger_i 00→1, 01→DEPTH/4, 10→DEPTH/2, 11→DEPTH-2 (DEPTH=16 gives 1/4/8/14). In non-FIFO mode trigger_o = dr_o.
- fifo_error_o: an error counter of width $clog2(DEPTH+1)
  - increments on an accepted write with any tag set;
  - decrements on a pop of a head with any tag set;
  - both in the same cycle leave it unchanged.
  - fifo_error_o = (counter != 0).
- Timeout (FIFO mode only):
  - Counter increments on char_tick_i while dr_o=1.
  - Counter clears on any accepted write, any accepted read, clr_i, or dr_o=0.
  - timeout_o sets when the counter reaches TIMEOUT_CHARS. It holds, with the counter saturated, until one of the clear events.
  - Always 0 when ena_i=0.
- Flush: clr_i=1, or an ena_i value differing from its registered previous value, empties the buffer next cycle: count, pointers, error counter, timeout all 0.
  - A write in the flush cycle is discarded without overrun.
  - Flush has priority over rd_i and wr_i.
- Reset mid-operation: all state returns to reset values immediately, with no glitches on the registered outputs after release.

Test Plan:
- After reset, ena_i=1, trigger_i=10, write 0x41..0x48 → trigger_o rises on the cycle after the 8th write with count_o=8; reads return 0x41..0x48 in order, then dr_o=0 and rd_d_o=0.
- Fill 16 entries, 17th write 0x99 alone → overrun_o pulses one cycle, count_o stays 16, head still the first char. Repeat with rd_i asserted on the same cycle → no overrun, 0x99 read last.
- Write chars 2 and 5 with fe=1 (of 6) → fifo_error_o=1; stays 1 after popping char 2; clears the cycle after popping char 5.
- Write 3 chars then idle, TIMEOUT_CHARS=4 → timeout_o asserts on the cycle after the 4th char_tick_i; one rd_i clears it; 4 further ticks re-assert it.
- ena_i=0: write 0x10, write 0x20 → second write overruns, full_o=1 with count_o=1, trigger_o=dr_o; toggle ena_i to 1 → buffer flushed, count_o=0.
- clr_i coincident with wr_i at count 5 → count_o=0 next cycle, no overrun; rst_i asserted mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: parametrised UART receive FIFO with per-character error
// tags and LSR/IIR status (data ready, trigger, FIFO error, overrun, timeout).
// With ena_i=0 it behaves as the single-entry holding register of a 16550.
module uart_rx_buffer #(
    parameter int DEPTH         = 16,
    parameter int DATA_SIZE     = 8,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         ena_i,
    input  logic                         clr_i,
    input  logic [1:0]                   trigger_i,
    input  logic                         char_tick_i,
    input  logic                         wr_i,
    input  logic [DATA_SIZE-1:0]         wr_d_i,
    input  logic                         wr_bi_i,
    input  logic                         wr_fe_i,
    input  logic                         wr_pe_i,
    input  logic                         rd_i,
    output logic [DATA_SIZE-1:0]         rd_d_o,
    output logic                         rd_bi_o,
    output logic                         rd_fe_o,
    output logic                         rd_pe_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         dr_o,
    output logic                         full_o,
    output logic                         trigger_o,
    output logic                         fifo_error_o,
    output logic                         overrun_o,
    output logic                         timeout_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(TIMEOUT_CHARS+1);
    localparam int EW = DATA_SIZE + 3;   // {bi, fe, pe, data}

    // Storage is deliberately not reset; count_q alone says what is valid.
    logic [EW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_q, timeout_d;
    logic          overrun_q, overrun_d;
    logic          ena_prev_q, ena_prev_d;

    logic [CW-1:0] eff_depth;
    logic [CW-1:0] trig_level;
    logic [EW-1:0] head;
    logic          flush;
    logic          dr;
    logic          full;
    logic          head_err;
    logic          wr_err;
    logic          do_rd;
    logic          do_wr;
    logic          tmo_clear;

    // Rx trigger level decode from the FCR encoding.
    always_comb begin
        trig_level = CW'(1);
        case (trigger_i)
            2'b01:   trig_level = CW'(DEPTH/4);
            2'b10:   trig_level = CW'(DEPTH/2);
            2'b11:   trig_level = CW'(DEPTH-2);
            default: trig_level = CW'(1);
        endcase
    end

    // Accept/reject decisions for this cycle; flush overrides both strobes.
    always_comb begin
        ena_prev_d = ena_i;
        flush      = clr_i | (ena_i != ena_prev_q);
        eff_depth  = ena_i ? CW'(DEPTH) : CW'(1);
        dr         = (count_q != '0);
        full       = (count_q == eff_depth);
        head       = mem_q[rd_ptr_q];
        head_err   = |head[EW-1:DATA_SIZE];
        wr_err     = wr_bi_i | wr_fe_i | wr_pe_i;
        do_rd      = rd_i & dr & ~flush;
        // A pop in the same cycle frees the slot, so a write while full is kept.
        do_wr      = wr_i & (~full | (rd_i & dr)) & ~flush;
        tmo_clear  = flush | do_wr | do_rd | ~dr | ~ena_i;
    end

    // Next-state for pointers, counters, timeout and overrun.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = 1'b0;
        overrun_d = 1'b0;

        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            err_cnt_d = '0;
            tmo_cnt_d = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);

            case ({do_wr, do_rd})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            case ({do_wr & wr_err, do_rd & head_err})
                2'b10:   err_cnt_d = err_cnt_q + CW'(1);
                2'b01:   err_cnt_d = err_cnt_q - CW'(1);
                default: err_cnt_d = err_cnt_q;
            endcase

            // Lost character: full, no room made by a pop this cycle.
            overrun_d = wr_i & full & ~(rd_i & dr);

            // Idle character counter saturates at the timeout threshold.
            if (tmo_clear) begin
                tmo_cnt_d = '0;
            end else if (char_tick_i && (tmo_cnt_q != TW'(TIMEOUT_CHARS))) begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
            timeout_d = ~tmo_clear & (tmo_cnt_d == TW'(TIMEOUT_CHARS));
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            ena_prev_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_cnt_q  <= err_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
            ena_prev_q <= ena_prev_d;
        end
    end

    // Character storage: tags and data written together at the write pointer.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= {wr_bi_i, wr_fe_i, wr_pe_i, wr_d_i};
        end
    end

    // Head is shown straight from storage but masked to zero when empty.
    always_comb begin
        rd_d_o       = dr ? head[DATA_SIZE-1:0] : '0;
        rd_bi_o      = dr & head[DATA_SIZE+2];
        rd_fe_o      = dr & head[DATA_SIZE+1];
        rd_pe_o      = dr & head[DATA_SIZE];
        count_o      = count_q;
        dr_o         = dr;
        full_o       = full;
        trigger_o    = ena_i ? (count_q >= trig_level) : dr;
        fifo_error_o = (err_cnt_q != '0);
        overrun_o    = overrun_q;
        timeout_o    = timeout_q & ena_i;
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: directed + randomized stimulus against a queue-based
// reference model; a negedge monitor compares every cycle's status and
// every read against expectations pushed by the driver.
module tb_uart_rx_buffer;

    localparam int DEPTH = 16;
    localparam int DS    = 8;
    localparam int TC    = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          ena_i;
    logic          clr_i;
    logic [1:0]    trigger_i;
    logic          char_tick_i;
    logic          wr_i;
    logic [DS-1:0] wr_d_i;
    logic          wr_bi_i, wr_fe_i, wr_pe_i;
    logic          rd_i;
    logic [DS-1:0] rd_d_o;
    logic          rd_bi_o, rd_fe_o, rd_pe_o;
    logic [CW-1:0] count_o;
    logic          dr_o, full_o, trigger_o, fifo_error_o, overrun_o, timeout_o;

    uart_rx_buffer #(.DEPTH(DEPTH), .DATA_SIZE(DS), .TIMEOUT_CHARS(TC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ena_i(ena_i), .clr_i(clr_i),
        .trigger_i(trigger_i), .char_tick_i(char_tick_i),
        .wr_i(wr_i), .wr_d_i(wr_d_i), .wr_bi_i(wr_bi_i), .wr_fe_i(wr_fe_i), .wr_pe_i(wr_pe_i),
        .rd_i(rd_i), .rd_d_o(rd_d_o), .rd_bi_o(rd_bi_o), .rd_fe_o(rd_fe_o), .rd_pe_o(rd_pe_o),
        .count_o(count_o), .dr_o(dr_o), .full_o(full_o), .trigger_o(trigger_o),
        .fifo_error_o(fifo_error_o), .overrun_o(overrun_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int count;
        bit dr, full, trig, ferr, ovr, tmo;
        int head;
    } exp_t;

    // Reference model state: held characters as (tags<<8)|data.
    int   mq[$];
    int   idle;
    bit   ovr_m;
    bit   ena_prev_m;

    exp_t exp_q[$];
    int   dq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   n_reads = 0;
    exp_t mon_e;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int level(input int tr);
        case (tr)
            1:       return DEPTH/4;
            2:       return DEPTH/2;
            3:       return DEPTH-2;
            default: return 1;
        endcase
    endfunction

    function automatic bit any_err();
        foreach (mq[i]) if ((mq[i] >> 8) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t cur_status();
        exp_t e;
        int   eff;
        eff    = ena_i ? DEPTH : 1;
        e.count = mq.size();
        e.dr   = (mq.size() != 0);
        e.full = (mq.size() == eff);
        e.trig = ena_i ? (mq.size() >= level(int'(trigger_i))) : e.dr;
        e.ferr = any_err();
        e.ovr  = ovr_m;
        e.tmo  = ena_i && (idle >= TC);
        e.head = e.dr ? mq[0] : 0;
        return e;
    endfunction

    // One clock of stimulus; expectation for this cycle is queued, then the model steps.
    task automatic cyc(input bit wr, input int d, input int tags, input bit rd, input bit tick, input bit clr);
        bit flush, full, rd_ok, wr_ok;
        int old, eff;
        wr_i = wr; wr_d_i = d[7:0];
        wr_bi_i = tags[2]; wr_fe_i = tags[1]; wr_pe_i = tags[0];
        rd_i = rd; char_tick_i = tick; clr_i = clr;
        exp_q.push_back(cur_status());
        if (rd && mq.size() > 0) dq.push_back(mq[0]);
        flush = clr || (ena_i != ena_prev_m);
        ena_prev_m = ena_i;
        if (flush) begin
            mq.delete(); idle = 0; ovr_m = 0;
        end else begin
            eff   = ena_i ? DEPTH : 1;
            old   = mq.size();
            full  = (old == eff);
            rd_ok = rd && old > 0;
            wr_ok = wr && (!full || rd_ok);
            ovr_m = wr && full && !rd_ok;
            if (rd_ok) void'(mq.pop_front());
            if (wr_ok) mq.push_back(((tags & 7) << 8) | (d & 255));
            if (!ena_i || rd_ok || wr_ok || old == 0) idle = 0;
            else if (tick && idle < TC) idle++;
        end
        @(posedge clk_i); #1;
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0);
    endtask

    // Reset is raised between clock edges so its effect is seen before any edge.
    task automatic do_reset(input int n);
        wr_i = 0; rd_i = 0; clr_i = 0; char_tick_i = 0;
        rst_i = 1;
        mq.delete(); idle = 0; ovr_m = 0; ena_prev_m = 0;
        repeat (n) begin
            exp_q.push_back(cur_status());
            @(posedge clk_i); #1;
        end
        rst_i = 0;
    endtask

    // Monitor: compare status every cycle and data on every accepted read.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("count",      int'(count_o),      mon_e.count);
            chk("dr",         int'(dr_o),         int'(mon_e.dr));
            chk("full",       int'(full_o),       int'(mon_e.full));
            chk("trigger",    int'(trigger_o),    int'(mon_e.trig));
            chk("fifo_error", int'(fifo_error_o), int'(mon_e.ferr));
            chk("overrun",    int'(overrun_o),    int'(mon_e.ovr));
            chk("timeout",    int'(timeout_o),    int'(mon_e.tmo));
            chk("head",       int'({rd_bi_o, rd_fe_o, rd_pe_o, rd_d_o}), mon_e.head);
        end
        if (rd_i && dr_o) begin
            n_reads++;
            if (dq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rd_data: got %0h expected none (no read pending) at %0t", rd_d_o, $time);
            end else begin
                chk("rd_data", int'({rd_bi_o, rd_fe_o, rd_pe_o, rd_d_o}), dq.pop_front());
                $display("read %0d: data=%02h tags=%0d%0d%0d", n_reads, rd_d_o, rd_bi_o, rd_fe_o, rd_pe_o);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wp, rp, tp, tg;
        rst_i = 1; ena_i = 1; clr_i = 0; trigger_i = 2'b10; char_tick_i = 0;
        wr_i = 0; wr_d_i = '0; wr_bi_i = 0; wr_fe_i = 0; wr_pe_i = 0; rd_i = 0;
        @(posedge clk_i); #1;
        do_reset(3);
        idle_cyc(2);

        // In-order data and trigger at level 8.
        for (int k = 0; k < 8; k++) cyc(1, 'h41 + k, 0, 0, 0, 0);
        idle_cyc(2);
        for (int k = 0; k < 8; k++) cyc(0, 0, 0, 1, 0, 0);
        idle_cyc(2);

        // Fill, overrun alone, then full write with simultaneous read.
        trigger_i = 2'b11;
        for (int k = 0; k < DEPTH; k++) cyc(1, 'h60 + k, 0, 0, 0, 0);
        cyc(1, 'h99, 0, 0, 0, 0);
        idle_cyc(2);
        cyc(1, 'h99, 0, 1, 0, 0);
        idle_cyc(1);
        for (int k = 0; k < DEPTH + 1; k++) cyc(0, 0, 0, 1, 0, 0);
        idle_cyc(1);

        // Framing-error tags on characters 2 and 5.
        trigger_i = 2'b01;
        for (int k = 1; k <= 6; k++) cyc(1, 'h30 + k, (k == 2 || k == 5) ? 2 : 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 0, 1, 0, 0);
            idle_cyc(1);
        end

        // Character timeout, cleared by a read and re-armed by further ticks.
        for (int k = 0; k < 3; k++) cyc(1, 'h50 + k, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 0, 1, 0);
            idle_cyc(1);
        end
        cyc(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 1, 0);
            idle_cyc(1);
        end
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle_cyc(1);

        // Holding-register mode, then re-enable flushes.
        ena_i = 0;
        idle_cyc(1);
        cyc(1, 'h10, 0, 0, 0, 0);
        cyc(1, 'h20, 0, 0, 0, 0);
        idle_cyc(2);
        ena_i = 1;
        idle_cyc(2);

        // Flush coincident with a write at count 5.
        for (int k = 0; k < 5; k++) cyc(1, 'h70 + k, 1, 0, 0, 0);
        cyc(1, 'h77, 0, 0, 0, 1);
        idle_cyc(2);

        // Randomized phases alternating fill-heavy, drain-heavy and idle-with-ticks.
        for (int p = 0; p < 12; p++) begin
            case (p % 3)
                0:       begin wp = 75; rp = 30; tp = 20; end
                1:       begin wp = 30; rp = 75; tp = 20; end
                default: begin wp = 8;  rp = 4;  tp = 60; end
            endcase
            for (int i = 0; i < 160; i++) begin
                if ($urandom_range(0, 249) == 0) ena_i = ~ena_i;
                if ($urandom_range(0, 39) == 0) trigger_i = 2'($urandom_range(0, 3));
                tg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
                cyc(($urandom_range(0, 99) < wp), int'($urandom_range(0, 255)), tg,
                    ($urandom_range(0, 99) < rp), ($urandom_range(0, 99) < tp),
                    ($urandom_range(0, 149) == 0));
            end
        end

        // Asynchronous reset in the middle of traffic.
        ena_i = 1;
        idle_cyc(2);
        for (int k = 0; k < 6; k++) cyc(1, 'h80 + k, (k == 3) ? 4 : 0, 0, 1, 0);
        do_reset(2);
        idle_cyc(3);

        @(negedge clk_i); #1;
        chk("status_queue_drained", exp_q.size(), 0);
        chk("read_queue_drained", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
